// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard and redirect controller for a 5-stage core.
//
// Turns per-stage busy/hazard indications into per-stage hold (stall) and
// bubble-insert (flush) vectors. It also sequences PC redirects from EX
// branches and MEM traps through a small FSM, so that the new PC is loaded
// only once instruction fetch is able to accept it.
//
// Ports
//   clk              in   clock, all state updates on posedge
//   rst              in   synchronous active-high reset
//   if_busy_i        in   instruction fetch in flight (IF cannot take a PC)
//   load_use_i       in   ID load-use hazard
//   ex_busy_i        in   multi-cycle EX operation not done
//   mem_busy_i       in   data memory access in flight
//   branch_valid_i   in   EX redirect request
//   branch_pc_i      in   EX redirect target
//   trap_valid_i     in   MEM trap/mret redirect request
//   trap_pc_i        in   MEM trap/mret redirect target
//   stall_valid_o    out  per-stage hold, indexed by CTRLBUS_*
//   flush_valid_o    out  per-stage bubble insert, indexed by CTRLBUS_*
//   redirect_valid_o out  PC load request (one cycle, in ISSUE)
//   redirect_pc_o    out  PC load target (always the pending target)
//   stall_cycles_o   out  number of cycles with the PC stage held
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

`ifndef CTRLBUS_PC
`define CTRLBUS_PC     0
`define CTRLBUS_IF_ID  1
`define CTRLBUS_ID_EX  2
`define CTRLBUS_EX_MEM 3
`define CTRLBUS_MEM_WB 4
`define CTRLBUS_RSVD   5
`endif

module pipe_ctrl (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_busy_i,
  input  logic              load_use_i,
  input  logic              ex_busy_i,
  input  logic              mem_busy_i,
  input  logic              branch_valid_i,
  input  logic [`XLEN-1:0]  branch_pc_i,
  input  logic              trap_valid_i,
  input  logic [`XLEN-1:0]  trap_pc_i,
  output logic [5:0]        stall_valid_o,
  output logic [5:0]        flush_valid_o,
  output logic              redirect_valid_o,
  output logic [`XLEN-1:0]  redirect_pc_o,
  output logic [63:0]       stall_cycles_o
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    WAIT_FETCH = 2'd1,
    ISSUE      = 2'd2
  } state_t;

  state_t             state;
  logic [`XLEN-1:0]   pend_pc;
  logic [63:0]        stall_cycles;

  logic [5:0]         haz_stall;
  logic [5:0]         haz_flush;
  logic               trap_acc;
  logic               br_acc;

  // A trap cannot be taken while the memory access that may have raised it
  // is still in flight. Branches come from EX, so they additionally wait for
  // EX to finish, lose to a simultaneous trap, and are dropped while a
  // redirect is already under way (they are on the wrong path then).
  assign trap_acc = !rst && trap_valid_i && !mem_busy_i;
  assign br_acc   = !rst && (state == RUN) && branch_valid_i &&
                    !mem_busy_i && !ex_busy_i && !trap_acc;

  // Hazard stalls: the oldest busy stage wins. Everything upstream of it is
  // held and the stage just downstream of it receives a bubble.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    haz_stall = 6'b000000;
    haz_flush = 6'b000000;
    if (mem_busy_i) begin
      haz_stall = 6'b001111;
      haz_flush = 6'b010000;
    end else if (ex_busy_i) begin
      haz_stall = 6'b000111;
      haz_flush = 6'b001000;
    end else if (load_use_i) begin
      haz_stall = 6'b000011;
      haz_flush = 6'b000100;
    end else if (if_busy_i) begin
      haz_stall = 6'b000001;
      haz_flush = 6'b000010;
    end
  end

  // Output composition, lowest to highest precedence:
  // hazard table -> redirect state overlay on bits 0-1 -> accepted trap or
  // branch overlay -> reset.
  always_comb begin
    stall_valid_o    = haz_stall;
    flush_valid_o    = haz_flush;
    redirect_valid_o = 1'b0;

    case (state)
      WAIT_FETCH: begin
        // Keep PC held and feed bubbles into IF_ID until fetch is free.
        stall_valid_o[`CTRLBUS_PC]    = 1'b1;
        stall_valid_o[`CTRLBUS_IF_ID] = 1'b0;
        flush_valid_o[`CTRLBUS_PC]    = 1'b0;
        flush_valid_o[`CTRLBUS_IF_ID] = 1'b1;
      end
      ISSUE: begin
        stall_valid_o[`CTRLBUS_PC]    = 1'b0;
        stall_valid_o[`CTRLBUS_IF_ID] = 1'b0;
        flush_valid_o[`CTRLBUS_PC]    = 1'b0;
        flush_valid_o[`CTRLBUS_IF_ID] = 1'b1;
        redirect_valid_o              = 1'b1;
      end
      default: ;
    endcase

    if (trap_acc) begin
      // Kill IF_ID, ID_EX and EX_MEM (the trapping instruction included);
      // a newer trap also supersedes a redirect about to issue.
      stall_valid_o[3:0] = 4'b0001;
      flush_valid_o[3:0] = 4'b1110;
      redirect_valid_o   = 1'b0;
    end else if (br_acc) begin
      // Kill the two younger instructions behind the branch.
      stall_valid_o[2:0] = 3'b001;
      flush_valid_o[2:0] = 3'b110;
    end

    if (rst) begin
      stall_valid_o    = 6'b000000;
      flush_valid_o    = 6'b011110;
      redirect_valid_o = 1'b0;
    end

    stall_valid_o[`CTRLBUS_RSVD] = 1'b0;
    flush_valid_o[`CTRLBUS_RSVD] = 1'b0;
  end

  // Redirect FSM, pending target and stall counter.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state        <= RUN;
      pend_pc      <= '0;
      stall_cycles <= '0;
    end else begin
      // Wraps naturally at 2^64.
      stall_cycles <= stall_cycles + 64'(stall_valid_o[`CTRLBUS_PC]);

      if (trap_acc || br_acc) begin
        pend_pc <= trap_acc ? trap_pc_i : branch_pc_i;
        state   <= if_busy_i ? WAIT_FETCH : ISSUE;
      end else begin
        case (state)
          WAIT_FETCH: if (!if_busy_i) state <= ISSUE;
          ISSUE:      state <= RUN;
          default:    state <= RUN;
        endcase
      end
    end
  end

  assign redirect_pc_o  = pend_pc;
  assign stall_cycles_o = stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl.
//
// Inputs change 1 ns after each rising edge; the combinational outputs are
// compared 1 ns later, well clear of the next edge. The expected stall
// counter is tracked by the bench from the expected stall vectors.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pipe_ctrl;

  localparam int XW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_busy_i;
  logic          load_use_i;
  logic          ex_busy_i;
  logic          mem_busy_i;
  logic          branch_valid_i;
  logic [XW-1:0] branch_pc_i;
  logic          trap_valid_i;
  logic [XW-1:0] trap_pc_i;
  logic [5:0]    stall_valid_o;
  logic [5:0]    flush_valid_o;
  logic          redirect_valid_o;
  logic [XW-1:0] redirect_pc_o;
  logic [63:0]   stall_cycles_o;

  int            checks  = 0;
  int            errors  = 0;
  logic [63:0]   exp_cnt = '0;
  logic          last_s0 = 1'b0;

  pipe_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .if_busy_i        (if_busy_i),
    .load_use_i       (load_use_i),
    .ex_busy_i        (ex_busy_i),
    .mem_busy_i       (mem_busy_i),
    .branch_valid_i   (branch_valid_i),
    .branch_pc_i      (branch_pc_i),
    .trap_valid_i     (trap_valid_i),
    .trap_pc_i        (trap_pc_i),
    .stall_valid_o    (stall_valid_o),
    .flush_valid_o    (flush_valid_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .stall_cycles_o   (stall_cycles_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    if_busy_i      = 1'b0;
    load_use_i     = 1'b0;
    ex_busy_i      = 1'b0;
    mem_busy_i     = 1'b0;
    branch_valid_i = 1'b0;
    branch_pc_i    = '0;
    trap_valid_i   = 1'b0;
    trap_pc_i      = '0;
  endtask

  // Compare all combinational outputs for the current cycle.
  task automatic expect_out(input string tag, input logic [5:0] s,
                            input logic [5:0] f, input logic rv,
                            input logic [XW-1:0] pc);
    #1;
    check({tag, ".stall"}, 64'(stall_valid_o), 64'(s));
    check({tag, ".flush"}, 64'(flush_valid_o), 64'(f));
    check({tag, ".rv"},    64'(redirect_valid_o), 64'(rv));
    check({tag, ".pc"},    64'(redirect_pc_o), 64'(pc));
    last_s0 = s[0];
  endtask

  // Advance one clock and update the expected stall counter.
  task automatic tick();
    @(posedge clk);
    if (rst) exp_cnt = '0;
    else     exp_cnt = exp_cnt + 64'(last_s0);
    #1;
  endtask

  initial begin
    // ---------------- reset, requests ignored ----------------
    idle();
    rst = 1'b1;
    trap_valid_i = 1'b1; trap_pc_i = 32'hDEAD_0000;
    branch_valid_i = 1'b1; branch_pc_i = 32'hBEEF_0000;
    #1;
    check("rst.stall", 64'(stall_valid_o), 64'h00);
    check("rst.flush", 64'(flush_valid_o), 64'h1E);
    check("rst.rv",    64'(redirect_valid_o), 64'h0);
    last_s0 = 1'b0;
    tick();
    expect_out("rst2", 6'b000000, 6'b011110, 1'b0, 32'h0);
    check("rst2.cnt", stall_cycles_o, 64'h0);
    tick();
    idle(); rst = 1'b0;
    expect_out("run0", 6'b000000, 6'b000000, 1'b0, 32'h0);
    check("run0.cnt", stall_cycles_o, 64'h0);
    tick();

    // ---------------- hazard priority table ----------------
    mem_busy_i = 1'b1; load_use_i = 1'b1;
    expect_out("haz_mem", 6'b001111, 6'b010000, 1'b0, 32'h0);
    tick();
    idle(); ex_busy_i = 1'b1; if_busy_i = 1'b1;
    expect_out("haz_ex", 6'b000111, 6'b001000, 1'b0, 32'h0);
    tick();
    idle(); load_use_i = 1'b1; if_busy_i = 1'b1;
    expect_out("haz_lu", 6'b000011, 6'b000100, 1'b0, 32'h0);
    tick();
    idle(); if_busy_i = 1'b1;
    expect_out("haz_if", 6'b000001, 6'b000010, 1'b0, 32'h0);
    tick();
    idle();
    expect_out("haz_none", 6'b000000, 6'b000000, 1'b0, 32'h0);
    check("haz.cnt", stall_cycles_o, 64'd4);
    check("haz.cnt_model", stall_cycles_o, exp_cnt);
    tick();

    // ---------------- branch, fetch free ----------------
    branch_valid_i = 1'b1; branch_pc_i = 32'h8000_0100;
    expect_out("br_acc", 6'b000001, 6'b000110, 1'b0, 32'h0);
    tick();
    idle();
    expect_out("br_issue", 6'b000000, 6'b000010, 1'b1, 32'h8000_0100);
    tick();
    expect_out("br_run", 6'b000000, 6'b000000, 1'b0, 32'h8000_0100);
    tick();

    // ---------------- trap held off by mem_busy ----------------
    trap_valid_i = 1'b1; trap_pc_i = 32'h8000_0300; mem_busy_i = 1'b1;
    expect_out("trap_blk", 6'b001111, 6'b010000, 1'b0, 32'h8000_0100);
    tick();
    mem_busy_i = 1'b0;
    expect_out("trap_acc", 6'b000001, 6'b001110, 1'b0, 32'h8000_0100);
    tick();
    idle();
    expect_out("trap_issue", 6'b000000, 6'b000010, 1'b1, 32'h8000_0300);
    tick();
    check("trap.cnt", stall_cycles_o, 64'd7);

    // ---------------- trap with fetch busy for 3 cycles ----------------
    trap_valid_i = 1'b1; trap_pc_i = 32'h8000_0004; if_busy_i = 1'b1;
    expect_out("wf_acc", 6'b000001, 6'b001110, 1'b0, 32'h8000_0300);
    tick();
    idle(); if_busy_i = 1'b1;
    expect_out("wf_1", 6'b000001, 6'b000010, 1'b0, 32'h8000_0004);
    tick();
    load_use_i = 1'b1;
    expect_out("wf_2_lu", 6'b000001, 6'b000110, 1'b0, 32'h8000_0004);
    tick();
    idle();
    expect_out("wf_3", 6'b000001, 6'b000010, 1'b0, 32'h8000_0004);
    tick();
    expect_out("wf_issue", 6'b000000, 6'b000010, 1'b1, 32'h8000_0004);
    tick();
    expect_out("wf_run", 6'b000000, 6'b000000, 1'b0, 32'h8000_0004);
    check("wf.cnt", stall_cycles_o, 64'd11);
    tick();

    // ------- branch ignored in WAIT_FETCH, then trap overrides -------
    branch_valid_i = 1'b1; branch_pc_i = 32'h8000_0400; if_busy_i = 1'b1;
    expect_out("ig_acc", 6'b000001, 6'b000110, 1'b0, 32'h8000_0004);
    tick();
    branch_pc_i = 32'h8000_0500;
    expect_out("ig_br", 6'b000001, 6'b000010, 1'b0, 32'h8000_0400);
    tick();
    idle(); trap_valid_i = 1'b1; trap_pc_i = 32'h8000_0200;
    expect_out("ig_trap", 6'b000001, 6'b001110, 1'b0, 32'h8000_0400);
    tick();
    idle();
    expect_out("ig_issue", 6'b000000, 6'b000010, 1'b1, 32'h8000_0200);
    tick();
    expect_out("ig_run", 6'b000000, 6'b000000, 1'b0, 32'h8000_0200);
    tick();

    // ------- trap arriving in ISSUE suppresses the pulse -------
    branch_valid_i = 1'b1; branch_pc_i = 32'h8000_0600;
    expect_out("is_acc", 6'b000001, 6'b000110, 1'b0, 32'h8000_0200);
    tick();
    idle(); trap_valid_i = 1'b1; trap_pc_i = 32'h8000_0700; if_busy_i = 1'b1;
    expect_out("is_trap", 6'b000001, 6'b001110, 1'b0, 32'h8000_0600);
    tick();
    idle();
    expect_out("is_wf", 6'b000001, 6'b000010, 1'b0, 32'h8000_0700);
    tick();
    ex_busy_i = 1'b1;
    expect_out("is_issue_ex", 6'b000100, 6'b001010, 1'b1, 32'h8000_0700);
    tick();
    idle();
    check("is.cnt", stall_cycles_o, 64'd17);
    check("is.cnt_model", stall_cycles_o, exp_cnt);

    // ---------------- reset while in ISSUE ----------------
    branch_valid_i = 1'b1; branch_pc_i = 32'h8000_0800;
    expect_out("rs_acc", 6'b000001, 6'b000110, 1'b0, 32'h8000_0700);
    tick();
    idle(); rst = 1'b1;
    expect_out("rs_issue", 6'b000000, 6'b011110, 1'b0, 32'h8000_0800);
    tick();
    rst = 1'b0;
    expect_out("rs_after", 6'b000000, 6'b000000, 1'b0, 32'h0);
    check("rs.cnt", stall_cycles_o, 64'h0);
    tick();
    expect_out("rs_after2", 6'b000000, 6'b000000, 1'b0, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port if_busy_i  in  1  instruction fetch in flight; IF cannot take a new PC.
REQ-004 SHALL have port load_use_i  in  1  ID load-use hazard.
REQ-005 SHALL have port ex_busy_i  in  1  multi-cycle EX op (mul/div) not done.
REQ-006 SHALL have port mem_busy_i  in  1  data memory access in flight.
REQ-007 SHALL have ports branch_valid_i / branch_pc_i  in  1 / `XLEN  EX redirect request and target.
REQ-008 SHALL have ports trap_valid_i / trap_pc_i  in  1 / `XLEN  MEM trap/mret redirect request and target.
REQ-009 SHALL have port stall_valid_o  out  6  per-stage hold, indexed by `CTRLBUS_* (0 PC, 1 IF_ID, 2 ID_EX, 3 EX_MEM, 4 MEM_WB, 5 reserved).
REQ-010 SHALL have port flush_valid_o  out  6  per-stage bubble insert, same indexing.
REQ-011 SHALL have ports redirect_valid_o / redirect_pc_o  out  1 / `XLEN  PC load request and target.
REQ-012 SHALL have port stall_cycles_o  out  64  count of cycles with stall_valid_o[0]=1.

Function
REQ-013 SHALL never assert stall_valid_o[i] and flush_valid_o[i] together for any i; bit 5 of both SHALL always be 0.
REQ-014 SHALL apply hazard stalls by priority mem_busy > ex_busy > load_use > if_busy, first match only: mem_busy: stall 0-3, flush 4; ex_busy: stall 0-2, flush 3; load_use: stall 0-1, flush 2; if_busy: stall 0, flush 1; none: all 0.
REQ-015 SHALL implement FSM states RUN, WAIT_FETCH, ISSUE and a pending-target register pend_pc (`XLEN).
REQ-016 SHALL accept trap_valid_i only when mem_busy_i=0; accepted trap: pend_pc<=trap_pc_i, flush bits 1-3 and stall bit 0 that cycle (overrides REQ-014 for bits 0-3).
REQ-017 SHALL accept branch_valid_i only in RUN with mem_busy_i=0, ex_busy_i=0, trap not accepted; accepted branch: pend_pc<=branch_pc_i, flush bits 1-2 and stall bit 0 that cycle.
REQ-018 SHALL, on acceptance, go to WAIT_FETCH if if_busy_i=1, else ISSUE.
REQ-019 SHALL in WAIT_FETCH hold stall bit 0, force flush bit 1 (stall bit 1 = 0); move to ISSUE in the cycle after if_busy_i samples 0.
REQ-020 SHALL in ISSUE drive redirect_valid_o=1, redirect_pc_o=pend_pc, stall bit 0 = 0, flush bit 1 = 1, for exactly one cycle, then return to RUN.
REQ-021 SHALL ignore branch_valid_i in WAIT_FETCH and ISSUE (wrong path).
REQ-022 SHALL, on trap accepted in WAIT_FETCH or ISSUE, overwrite pend_pc, suppress redirect_valid_o that cycle, and re-enter per REQ-018.
REQ-023 SHALL combine REQ-014 for bits 2-4 with REQ-019/020 in WAIT_FETCH/ISSUE; bits 0-1 follow REQ-019/020.
REQ-024 SHALL drive redirect_pc_o=pend_pc at all times; redirect_valid_o=0 outside ISSUE.
REQ-025 SHALL increment stall_cycles_o by 1 each cycle stall_valid_o[0]=1, wrapping 2^64-1 -> 0.

Reset
REQ-026 SHALL, while rst=1, go to RUN, clear pend_pc and stall_cycles_o, drive stall_valid_o=0, flush_valid_o=6'b011110, redirect_valid_o=0, ignoring all request inputs.
REQ-027 SHALL, on rst mid-redirect (WAIT_FETCH/ISSUE), drop the pending redirect with no redirect_valid_o pulse.

Verification
REQ-028 SHALL cover: mem_busy_i=1 and load_use_i=1 -> stall=6'b001111, flush=6'b010000.
REQ-029 SHALL cover: branch_valid_i=1, pc=0x80000100, if_busy_i=0 -> that cycle flush=6'b000110, stall=6'b000001; next cycle redirect_valid_o=1, redirect_pc_o=0x80000100.
REQ-030 SHALL cover: trap 0x80000004 accepted with if_busy_i=1 for 3 cycles -> WAIT_FETCH 3 cycles with flush bit 1; redirect_valid_o pulses once, after if_busy_i falls.
REQ-031 SHALL cover: in WAIT_FETCH branch_valid_i=1 (ignored), then trap 0x80000200 -> redirect_pc_o=0x80000200, single pulse.
REQ-032 SHALL cover: trap_valid_i=1 with mem_busy_i=1 -> not accepted, state RUN; accepted in first cycle mem_busy_i=0.
REQ-033 SHALL cover: rst asserted in ISSUE -> no redirect pulse, flush=6'b011110, stall_cycles_o=0 next cycle.
